// File: rtl/red_reduce.sv
// red_reduce: two-stage pipelined byte-reduction unit for the WISC RED instruction.
// Each 16-bit operand is split into two signed bytes. All four bytes are summed
// with full signed precision: stage 1 adds the low lanes and the high lanes
// separately, and stage 2 adds the two partial sums. The 10-bit result is
// sign-extended to 16 bits. The unit accepts one operation per cycle.
module red_reduce #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] Rs,
  input  logic [WIDTH-1:0] Rt,
  output logic             out_valid,
  output logic [WIDTH-1:0] Rd
);

  // One 4-bit carry-lookahead block. The result is {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[4], p ^ c[3:0]};
  endfunction

  // 9-bit adder for two byte values that are already sign-extended.
  // Two CLA blocks cover bits 7:0, and a single sum cell forms the sign bit.
  // No carry leaves bit 8 because the sum of two 9-bit signed bytes cannot overflow.
  function automatic logic [8:0] add9(input logic [8:0] a, input logic [8:0] b);
    logic [4:0] r0;
    logic [4:0] r1;
    r0 = cla4(a[3:0], b[3:0], 1'b0);
    r1 = cla4(a[7:4], b[7:4], r0[4]);
    return {a[8] ^ b[8] ^ r1[4], r1[3:0], r0[3:0]};
  endfunction

  // 10-bit adder for two partial sums that are already sign-extended.
  // Two CLA blocks cover bits 7:0, and a 2-bit lookahead tail covers bits 9:8.
  function automatic logic [9:0] add10(input logic [9:0] a, input logic [9:0] b);
    logic [4:0] r0;
    logic [4:0] r1;
    logic       c9;
    r0 = cla4(a[3:0], b[3:0], 1'b0);
    r1 = cla4(a[7:4], b[7:4], r0[4]);
    c9 = (a[8] & b[8]) | ((a[8] ^ b[8]) & r1[4]);
    return {a[9] ^ b[9] ^ c9, a[8] ^ b[8] ^ r1[4], r1[3:0], r0[3:0]};
  endfunction

  // ---- stage p0: operand lanes, sign-extended to 9 bits ----
  logic signed [8:0] rs_lo_p0, rt_lo_p0, rs_hi_p0, rt_hi_p0;
  logic signed [8:0] lo_sum_p0, hi_sum_p0;

  assign rs_lo_p0  = {Rs[7],  Rs[7:0]};
  assign rt_lo_p0  = {Rt[7],  Rt[7:0]};
  assign rs_hi_p0  = {Rs[15], Rs[15:8]};
  assign rt_hi_p0  = {Rt[15], Rt[15:8]};
  assign lo_sum_p0 = add9(rs_lo_p0, rt_lo_p0);
  assign hi_sum_p0 = add9(rs_hi_p0, rt_hi_p0);

  // ---- stage p1: registered lane sums ----
  logic signed [8:0] lo_sum_p1, hi_sum_p1;
  logic              vld_p1;

  // Stage 1: capture the lane sums only on a valid op. The valid bit is captured every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_sum_p1 <= '0;
      hi_sum_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        lo_sum_p1 <= lo_sum_p0;
        hi_sum_p1 <= hi_sum_p0;
      end
    end
  end

  logic signed [9:0] lo_ext_p1, hi_ext_p1, sum_p1;

  assign lo_ext_p1 = {lo_sum_p1[8], lo_sum_p1};
  assign hi_ext_p1 = {hi_sum_p1[8], hi_sum_p1};
  assign sum_p1    = add10(lo_ext_p1, hi_ext_p1);

  // ---- stage p2: registered sign-extended result ----
  logic signed [WIDTH-1:0] rd_p2;
  logic                    vld_p2;

  // Stage 2: update Rd only when stage 1 held a valid op, so Rd keeps the last result when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_p2  <= '0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        rd_p2 <= {{(WIDTH-10){sum_p1[9]}}, sum_p1};
      end
    end
  end

  assign Rd        = rd_p2;
  assign out_valid = vld_p2;

endmodule

// File: tb/tb_red_reduce.sv
// tb_red_reduce: directed and randomised checks of the red_reduce byte-reduction pipeline.
module tb_red_reduce;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] Rs, Rt;
  logic        out_valid;
  logic [15:0] Rd;

  int total = 0;
  int bad   = 0;

  // Two-entry model of operations in flight: index 1 is the next one expected at the output.
  logic        pv [0:1];
  logic [15:0] pe [0:1];
  logic [15:0] last_rd;

  red_reduce #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .Rs        (Rs),
    .Rt        (Rt),
    .out_valid (out_valid),
    .Rd        (Rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%04h expected=0x%04h", tag, got, exp);
    end
  endtask

  // Signed four-byte sum computed directly with integer arithmetic.
  function automatic logic [15:0] ref_red(input logic [15:0] a, input logic [15:0] b);
    logic signed [7:0] al, ah, bl, bh;
    int s;
    al = a[7:0];
    ah = a[15:8];
    bl = b[7:0];
    bh = b[15:8];
    s  = int'(al) + int'(ah) + int'(bl) + int'(bh);
    return s[15:0];
  endfunction

  // One cycle, run at the falling edge: check the op issued two cycles earlier, then drive the next op.
  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] exp);
    @(negedge clk);
    chk("out_valid", {15'd0, out_valid}, {15'd0, pv[1]});
    if (pv[1]) begin
      chk("rd", Rd, pe[1]);
      last_rd = pe[1];
    end else begin
      chk("rd_hold", Rd, last_rd);
    end
    pv[1] = pv[0];
    pe[1] = pe[0];
    pv[0] = v;
    pe[0] = exp;
    in_valid = v;
    Rs = a;
    Rt = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 16'h0000, 16'h0000);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    Rs       = '0;
    Rt       = '0;
    pv[0] = 1'b0; pv[1] = 1'b0;
    pe[0] = '0;   pe[1] = '0;
    last_rd = '0;
    #1;
    chk("reset_rd", Rd, 16'h0000);
    chk("reset_vld", {15'd0, out_valid}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single operations at the corners of the result range.
    step(1'b1, 16'h7F7F, 16'h7F7F, 16'h01FC);
    idle(3);
    step(1'b1, 16'h8080, 16'h8080, 16'hFE00);
    idle(3);
    step(1'b1, 16'hFF01, 16'h01FF, 16'h0000);
    idle(3);
    step(1'b1, 16'h1234, 16'h5678, 16'h0114);
    idle(3);
    step(1'b1, 16'h7F80, 16'h807F, 16'hFFFE);
    idle(2);
    step(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFC);
    idle(3);

    // Three back-to-back ops, then idle while the last result is held.
    step(1'b1, 16'h7F7F, 16'h7F7F, 16'h01FC);
    step(1'b1, 16'h8080, 16'h8080, 16'hFE00);
    step(1'b1, 16'h1234, 16'h5678, 16'h0114);
    idle(5);

    // Assert reset between edges while an op is in flight.
    step(1'b1, 16'h8080, 16'h8080, 16'hFE00);
    step(1'b1, 16'h7F7F, 16'h7F7F, 16'h01FC);
    @(posedge clk);
    #2;
    chk("pre_rst_vld", {15'd0, out_valid}, 16'h0001);
    chk("pre_rst_rd", Rd, 16'hFE00);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rd", Rd, 16'h0000);
    chk("async_rst_vld", {15'd0, out_valid}, 16'h0000);
    in_valid = 1'b0;
    pv[0] = 1'b0; pv[1] = 1'b0;
    last_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    // Random operands with in_valid toggled at random.
    for (int i = 0; i < 200; i++) begin
      logic        v;
      logic [15:0] a, b;
      v = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      b = 16'($urandom);
      step(v, a, b, ref_red(a, b));
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/red_reduce.md
Name: red_reduce

Overview:
- Pipelined 16-bit byte-reduction unit that executes the RED instruction in the WISC execute stage.
- Treats each 16-bit source as two signed bytes and adds all four bytes together: (RsLo+RtLo) + (RsHi+RtHi).
- Produces the sign-extended 16-bit sum two cycles after the operands are accepted.
- Fully pipelined: accepts one operation per cycle with no stalls.

Parameters:
- WIDTH, 16, operand/result width; must be 16 (two 8-bit lanes). Other values are unsupported.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  Rs/Rt carry a valid RED operation this cycle
- Rs  input  16  source operand; [15:8]=RsHi, [7:0]=RsLo, each signed two's complement
- Rt  input  16  source operand; [15:8]=RtHi, [7:0]=RtLo, each signed two's complement
- out_valid  output  1  Rd holds a new result this cycle
- Rd  output  16  sign-extended reduction result

Behaviour:
- Arithmetic: Rd = sext16( sext(RsLo)+sext(RtLo)+sext(RsHi)+sext(RtHi) ).
  - Full-precision signed math, no saturation, no overflow flag.
  - Result range is -512..+508, so 10 bits suffice; Rd[15:9] always equals Rd[9].
- Stage 1, on the rising edge when in_valid=1:
  - lo_sum = sext9(RsLo)+sext9(RtLo), a 9-bit signed value, registered.
  - hi_sum = sext9(RsHi)+sext9(RtHi), a 9-bit signed value, registered.
  - v1 <= in_valid is registered every cycle.
- Stage 2, on the rising edge when v1=1:
  - Rd <= sext16(sext10(lo_sum)+sext10(hi_sum)).
  - out_valid <= v1 is registered every cycle.
- Adders are built from 4-bit carry-lookahead blocks, with the sign extension applied before the adds.
- Latency is exactly 2 cycles: in_valid at edge N gives out_valid=1 and a valid Rd after edge N+2.
- Throughput is 1 per cycle. Back-to-back valids produce back-to-back results in order.
- When in_valid=0:
  - Stage-1 data registers hold their value.
  - When v1=0, Rd holds its last result and out_valid=0.
- No backpressure: out_valid is a one-cycle qualifier and downstream must capture Rd on it.
- Reset (rst_n=0, asynchronous, overrides any in-flight operation):
  - lo_sum, hi_sum, v1, Rd and out_valid all clear to 0 immediately.
  - Operations in flight are discarded; no out_valid pulse is produced for them after reset is released.
- The output depends only on the registered values; there is no combinational path from Rs/Rt/in_valid to Rd/out_valid.
- X-free: every register has a reset value.

Test Plan:
- Max positive: Rs=0x7F7F, Rt=0x7F7F, in_valid pulse -> two cycles later out_valid=1, Rd=0x01FC (+508).
- Max negative: Rs=0x8080, Rt=0x8080 -> Rd=0xFE00 (-512), upper bits fully sign-extended.
- Mixed signs cancel: Rs=0xFF01, Rt=0x01FF -> Rd=0x0000. Rs=0x1234, Rt=0x5678 -> Rd=0x0114 (276).
- Pipelining: drive valids on 3 consecutive cycles with (0x7F7F,0x7F7F), (0x8080,0x8080), (0x1234,0x5678) -> out_valid high for 3 consecutive cycles with Rd=0x01FC, 0xFE00, 0x0114 in order. Then in_valid=0 -> out_valid=0 and Rd holds 0x0114.
- Reset mid-flight: in_valid=1 with Rs=0x7F7F, Rt=0x7F7F, then assert rst_n=0 between clock edges before the result emerges -> Rd=0 and out_valid=0 immediately. After release, no out_valid appears until a new in_valid.
- Random: 200 random Rs/Rt with in_valid randomly toggled -> every out_valid Rd matches the signed four-byte sum (a 10-bit value sign-extended to 16 bits) of the operand issued two cycles earlier.
